// File: rtl/pixel_stream_source.sv
// Raster test-pattern transmitter: background frame with one bright rectangle,
// streamed over a valid/ready pixel interface with line and frame blanking.
module pixel_stream_source #(
    parameter int          H_ACTIVE  = 16,
    parameter int          V_ACTIVE  = 12,
    parameter int          H_BLANK   = 4,
    parameter int          V_BLANK   = 2,
    parameter int          COORD_W   = 8,
    parameter logic [7:0]  BG_LEVEL  = 8'h10,
    parameter logic [7:0]  OBJ_LEVEL = 8'h90
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               continuous,
    input  logic               abort,
    input  logic [COORD_W-1:0] obj_x,
    input  logic [COORD_W-1:0] obj_y,
    input  logic [COORD_W-1:0] obj_w,
    input  logic [COORD_W-1:0] obj_h,
    input  logic               pixel_ready,
    output logic [7:0]         pixel_data,
    output logic               pixel_valid,
    output logic               sof,
    output logic               eol,
    output logic               busy,
    output logic               frame_done
);

    localparam int BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int CNT_W     = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

    localparam logic [CNT_W-1:0]   H_LAST = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0]   V_LAST = CNT_W'(V_BLANK - 1);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_HBLANK,
        S_VBLANK
    } state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W-1:0] sx_q, sx_d, sy_q, sy_d, sw_q, sw_d, sh_q, sh_d;
    logic               latch_obj;
    logic               done_d;

    logic [7:0] pixel_data_q, pixel_data_d;
    logic       pixel_valid_q, pixel_valid_d;
    logic       sof_q, sof_d;
    logic       eol_q, eol_d;
    logic       busy_q, busy_d;
    logic       frame_done_q;

    // Rectangle bounds are formed one bit wider so x+w never wraps back into the frame.
    function automatic logic in_object(
        input logic [COORD_W-1:0] px,
        input logic [COORD_W-1:0] py,
        input logic [COORD_W-1:0] ox,
        input logic [COORD_W-1:0] oy,
        input logic [COORD_W-1:0] ow,
        input logic [COORD_W-1:0] oh
    );
        logic [COORD_W:0] x_end;
        logic [COORD_W:0] y_end;
        x_end = {1'b0, ox} + {1'b0, ow};
        y_end = {1'b0, oy} + {1'b0, oh};
        return (ow != '0) && (oh != '0) &&
               (px >= ox) && ({1'b0, px} < x_end) &&
               (py >= oy) && ({1'b0, py} < y_end);
    endfunction

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        latch_obj = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    latch_obj = 1'b1;
                    x_d       = '0;
                    y_d       = '0;
                    state_d   = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end else if (pixel_ready) begin
                    if (x_q != X_LAST) begin
                        x_d = x_q + COORD_W'(1);
                    end else begin
                        cnt_d   = '0;
                        state_d = (y_q != Y_LAST) ? S_HBLANK : S_VBLANK;
                    end
                end
            end
            S_HBLANK: begin
                if (abort) begin
                    state_d = S_IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end else if (cnt_q == H_LAST) begin
                    x_d     = '0;
                    y_d     = y_q + COORD_W'(1);
                    state_d = S_ACTIVE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_VBLANK: begin
                if (abort) begin
                    state_d = S_IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end else if (cnt_q == V_LAST) begin
                    // The done pulse shares its cycle with pixel (0,0) of a back-to-back frame.
                    done_d  = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    if (continuous) begin
                        latch_obj = 1'b1;
                        state_d   = S_ACTIVE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                x_d     = '0;
                y_d     = '0;
            end
        endcase

        sx_d = latch_obj ? obj_x : sx_q;
        sy_d = latch_obj ? obj_y : sy_q;
        sw_d = latch_obj ? obj_w : sw_q;
        sh_d = latch_obj ? obj_h : sh_q;

        // Outputs are precomputed from next state so they leave the block registered.
        pixel_valid_d = (state_d == S_ACTIVE);
        pixel_data_d  = 8'h00;
        if (pixel_valid_d) begin
            pixel_data_d = in_object(x_d, y_d, sx_d, sy_d, sw_d, sh_d) ? OBJ_LEVEL : BG_LEVEL;
        end
        sof_d  = pixel_valid_d && (x_d == '0) && (y_d == '0);
        eol_d  = pixel_valid_d && (x_d == X_LAST);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            cnt_q         <= '0;
            sx_q          <= '0;
            sy_q          <= '0;
            sw_q          <= '0;
            sh_q          <= '0;
            pixel_data_q  <= 8'h00;
            pixel_valid_q <= 1'b0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            cnt_q         <= cnt_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            sw_q          <= sw_d;
            sh_q          <= sh_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            sof_q         <= sof_d;
            eol_q         <= eol_d;
            busy_q        <= busy_d;
            frame_done_q  <= done_d;
        end
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;
    assign sof         = sof_q;
    assign eol         = eol_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source: a frame model fills a scoreboard queue and a
// negedge monitor checks every accepted pixel plus frame timing and control cases.
module tb_pixel_stream_source;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int HB = 2;
    localparam int VB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] obj_x = 8'd0;
    logic [7:0] obj_y = 8'd0;
    logic [7:0] obj_w = 8'd0;
    logic [7:0] obj_h = 8'd0;
    logic       pixel_ready = 1'b1;
    logic [7:0] pixel_data;
    logic       pixel_valid;
    logic       sof;
    logic       eol;
    logic       busy;
    logic       frame_done;

    pixel_stream_source #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .H_BLANK  (HB),
        .V_BLANK  (VB),
        .COORD_W  (8),
        .BG_LEVEL (8'h10),
        .OBJ_LEVEL(8'h90)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .abort      (abort),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_w      (obj_w),
        .obj_h      (obj_h),
        .pixel_ready(pixel_ready),
        .pixel_data (pixel_data),
        .pixel_valid(pixel_valid),
        .sof        (sof),
        .eol        (eol),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        bit         s;
        bit         e;
    } px_t;

    px_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  t0 = 0;
    int  done_cnt = 0;
    bit  sb_en = 1'b0;
    bit  rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference pixel rule: plain integer arithmetic, so no overflow and frame clipping is implicit.
    function automatic logic [7:0] px_val(input int x, input int y, input int ox, input int oy,
                                          input int ow, input int oh);
        if (ow > 0 && oh > 0 && x >= ox && x < ox + ow && y >= oy && y < oy + oh)
            return 8'h90;
        return 8'h10;
    endfunction

    function automatic void push_frame(input int ox, input int oy, input int ow, input int oh);
        px_t p;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                p.d = px_val(x, y, ox, oy, ow, oh);
                p.s = (x == 0 && y == 0);
                p.e = (x == H - 1);
                exp_q.push_back(p);
            end
        end
    endfunction

    // Monitor: one pixel popped per accepted transfer; idle cycles must drive zeros.
    always @(negedge clk) begin
        if (sb_en) begin
            if (frame_done) done_cnt++;
            if (pixel_valid) begin
                if (pixel_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_pixel: got data 0x%0h with empty scoreboard (cycle %0d)",
                                 pixel_data, cyc);
                    end else begin
                        px_t e;
                        e = exp_q.pop_front();
                        check("pixel{data,sof,eol}", int'({pixel_data, sof, eol}), int'({e.d, e.s, e.e}));
                    end
                end
            end else begin
                check("idle_outputs_zero", int'({pixel_data, sof, eol}), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_obj(input int ox, input int oy, input int ow, input int oh);
        obj_x = 8'(ox);
        obj_y = 8'(oy);
        obj_w = 8'(ow);
        obj_h = 8'(oh);
    endtask

    task automatic start_frame();
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        check(nm, int'({pixel_data, pixel_valid, sof, eol, busy, frame_done}), 0);
    endtask

    // Waits (bounded) for frame_done and checks latency from the start edge plus the done-cycle state.
    task automatic wait_done(input string nm, input int exp_lat, input bit exp_busy,
                             input bit exp_sof, input bit last);
        int n;
        bit got;
        int lat;
        bit bsy;
        bit sf;
        n   = 0;
        got = 1'b0;
        lat = 0;
        bsy = 1'b0;
        sf  = 1'b0;
        while (n < 400 && !got) begin
            @(negedge clk);
            n++;
            if (frame_done) begin
                got = 1'b1;
                lat = cyc - t0;
                bsy = busy;
                sf  = sof && pixel_valid;
            end
            @(posedge clk);
            #1;
            if (rand_ready) pixel_ready = ($urandom_range(0, 3) != 0);
        end
        check({nm, "_done_seen"}, int'(got), 1);
        if (got) begin
            if (exp_lat >= 0) check({nm, "_latency"}, lat, exp_lat);
            check({nm, "_busy_at_done"}, int'(bsy), int'(exp_busy));
            check({nm, "_sof_at_done"}, int'(sf), int'(exp_sof));
        end
        if (last) begin
            check({nm, "_pixels_left"}, exp_q.size(), 0);
            exp_q.delete();
        end
        $display("frame %s: done=%0d latency=%0d", nm, got, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        // Power-on reset
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset_state");
        tick();
        rst = 1'b0;
        tick();

        // 1: reset in the middle of a frame, start held during reset
        set_obj(2, 1, 3, 2);
        start_frame();
        repeat (5) tick();
        @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        tick();
        rst   = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) begin
                rst   = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
            check("reset_midframe_zero", int'({pixel_data, pixel_valid, sof, eol, busy, frame_done}), 0);
        end
        tick();
        @(negedge clk);
        check("start_ignored_in_reset", int'({pixel_valid, busy}), 0);
        tick();
        sb_en = 1'b1;
        $display("test1 reset mid-frame complete");

        // 2: single frame, rectangle (2,1,3,2)
        set_obj(2, 1, 3, 2);
        push_frame(2, 1, 3, 2);
        start_frame();
        wait_done("basic", 42, 1'b0, 1'b0, 1'b1);

        // 3: three-cycle stall while pixel (3,0) is presented
        push_frame(2, 1, 3, 2);
        start_frame();
        repeat (3) tick();
        pixel_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold{valid,data,sof,eol}", int'({pixel_valid, pixel_data, sof, eol}),
                  int'({1'b1, px_val(3, 0, 2, 1, 3, 2), 1'b0, 1'b0}));
            tick();
        end
        pixel_ready = 1'b1;
        wait_done("stall", 45, 1'b0, 1'b0, 1'b1);

        // 4: no object, then an object clipped at the right edge
        set_obj(3, 1, 0, 2);
        push_frame(3, 1, 0, 2);
        start_frame();
        wait_done("no_object", 42, 1'b0, 1'b0, 1'b1);
        set_obj(6, 0, 5, 1);
        push_frame(6, 0, 5, 1);
        start_frame();
        wait_done("clipped", 42, 1'b0, 1'b0, 1'b1);

        // start together with abort in IDLE must not launch a frame
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_with_abort_idle", int'({pixel_valid, busy}), 0);
        tick();

        // 5: continuous mode, object changed mid-frame applies to the next frame
        continuous = 1'b1;
        set_obj(1, 0, 2, 3);
        push_frame(1, 0, 2, 3);
        start_frame();
        repeat (10) tick();
        set_obj(5, 2, 3, 2);
        push_frame(5, 2, 3, 2);
        wait_done("cont_frame1", 42, 1'b1, 1'b1, 1'b0);
        continuous = 1'b0;
        wait_done("cont_frame2", 83, 1'b0, 1'b0, 1'b1);

        // 6: abort in the line blank after line 1
        set_obj(0, 0, 4, 4);
        push_frame(0, 0, 4, 4);
        start_frame();
        repeat (18) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_all_zero("abort_outputs_zero");
        check("abort_pixels_remaining", exp_q.size(), 2 * H);
        exp_q.delete();
        d0 = done_cnt;
        repeat (50) tick();
        check("abort_no_frame_done", done_cnt - d0, 0);
        push_frame(0, 0, 4, 4);
        start_frame();
        wait_done("after_abort", 42, 1'b0, 1'b0, 1'b1);

        // Randomized rectangles under random back-pressure
        rand_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int ox, oy, ow, oh;
            ox = $urandom_range(0, 9);
            oy = $urandom_range(0, 5);
            ow = $urandom_range(0, 9);
            oh = $urandom_range(0, 5);
            set_obj(ox, oy, ow, oh);
            push_frame(ox, oy, ow, oh);
            start_frame();
            wait_done($sformatf("random%0d", k), -1, 1'b0, 1'b0, 1'b1);
        end
        rand_ready  = 1'b0;
        pixel_ready = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
